// File: rtl/chs_pkg.sv
// Shared channel power definitions: ramp state encoding, level width and mode constants
// shared with the mode/power decoder.
package chs_pkg;

  localparam int unsigned CHS_PWR_W = 4;

  localparam logic CHS_MODE_STANDBY = 1'b0;
  localparam logic CHS_MODE_ACTIVE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } chs_state_t;

  // One-unit move toward target that holds rather than overshooting or wrapping.
  function automatic logic [CHS_PWR_W-1:0] chs_next_level(
    input logic [CHS_PWR_W-1:0] level,
    input logic [CHS_PWR_W-1:0] target,
    input logic                 up
  );
    if (up) return (level < target) ? level + 1'b1 : level;
    else    return (level > target) ? level - 1'b1 : level;
  endfunction

endpackage

// File: rtl/chs_power_ramp_step_timer.sv
// Modulo-STEP_CYCLES interval counter; o_tick marks the cycle whose closing edge
// should apply one level step.
module chs_step_timer #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chs_power_ramp.sv
// Channel power ramp: loads a decoded mode/power target and slews the applied level
// one unit per STEP_CYCLES toward it, with an overriding hard power cut.
module chs_power_ramp
  import chs_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_chs_mode,
  input  logic [CHS_PWR_W-1:0] i_chs_power,
  input  logic                 i_conf_valid,
  input  logic                 i_pwr_kill,
  output logic [CHS_PWR_W-1:0] o_pwr_level,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pwr_on
);

  chs_state_t           r_state;
  logic [CHS_PWR_W-1:0] r_level;
  logic [CHS_PWR_W-1:0] r_target;
  logic                 r_busy;
  logic                 r_done;

  logic [CHS_PWR_W-1:0] w_eff;
  logic [CHS_PWR_W-1:0] w_step_level;
  logic                 w_tick;

  assign w_eff        = (i_chs_mode == CHS_MODE_ACTIVE) ? i_chs_power : '0;
  assign w_step_level = chs_next_level(r_level, r_target, r_state == ST_UP);

  chs_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_step_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_pwr_kill | i_conf_valid),
    .i_en   (r_state != ST_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_level  <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_pwr_kill) begin
        r_state  <= ST_IDLE;
        r_level  <= '0;
        r_target <= '0;
        r_busy   <= 1'b0;
      end else if (i_conf_valid) begin
        // Level is left untouched here; a reload only redirects the ramp.
        r_target <= w_eff;
        if (w_eff > r_level) begin
          r_state <= ST_UP;
          r_busy  <= 1'b1;
        end else if (w_eff < r_level) begin
          r_state <= ST_DOWN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (r_state != ST_IDLE && w_tick) begin
        r_level <= w_step_level;
        if (w_step_level == r_target) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else if (w_step_level == r_level) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign o_pwr_level = r_level;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pwr_on    = (r_level != '0);

endmodule

// File: tb/tb_chs_power_ramp.sv
// Directed bench for chs_power_ramp at STEP_CYCLES=4; inputs change and outputs are
// sampled on the falling edge.
module tb_chs_power_ramp;

  logic       clk;
  logic       rst;
  logic       chs_mode;
  logic [3:0] chs_power;
  logic       conf_valid;
  logic       pwr_kill;
  logic [3:0] pwr_level;
  logic       busy;
  logic       done;
  logic       pwr_on;

  int n_cmp = 0;
  int n_err = 0;

  chs_power_ramp #(.STEP_CYCLES(4), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_chs_mode   (chs_mode),
    .i_chs_power  (chs_power),
    .i_conf_valid (conf_valid),
    .i_pwr_kill   (pwr_kill),
    .o_pwr_level  (pwr_level),
    .o_busy       (busy),
    .o_done       (done),
    .o_pwr_on     (pwr_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe a load across one rising edge; returns half a cycle after that edge.
  task automatic load(input logic m, input logic [3:0] p);
    chs_mode   = m;
    chs_power  = p;
    conf_valid = 1'b1;
    @(negedge clk);
    conf_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic b,
                         input logic d, input logic on);
    check({tag, ".level"}, {4'h0, pwr_level}, {4'h0, lvl});
    check({tag, ".busy"},  {7'h0, busy},      {7'h0, b});
    check({tag, ".done"},  {7'h0, done},      {7'h0, d});
    check({tag, ".pwr_on"},{7'h0, pwr_on},    {7'h0, on});
  endtask

  initial begin
    rst        = 1'b1;
    chs_mode   = 1'b0;
    chs_power  = 4'd0;
    conf_valid = 1'b0;
    pwr_kill   = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(5);
    chk_all("idle_hold", 4'd0, 1'b0, 1'b0, 1'b0);

    // Ramp 0 -> 3
    load(1'b1, 4'd3);
    chk_all("up.e0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk_all("up.e3", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_all("up.e4", 4'd1, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk_all("up.e8", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(3);
    chk_all("up.e11", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_all("up.e12", 4'd3, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk_all("up.e13", 4'd3, 1'b0, 1'b0, 1'b1);

    // Standby load forces the target to zero
    load(1'b0, 4'd9);
    chk_all("dn.e0", 4'd3, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk_all("dn.e4", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk_all("dn.e8", 4'd1, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk_all("dn.e12", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_all("dn.e13", 4'd0, 1'b0, 1'b0, 1'b0);

    // Reversal mid-ramp
    load(1'b1, 4'd10);
    tick(8);
    chk_all("rev.e8", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(2);
    load(1'b1, 4'd0);
    chk_all("rev.r0", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(3);
    chk_all("rev.r3", 4'd2, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_all("rev.r4", 4'd1, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk_all("rev.r8", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_all("rev.r9", 4'd0, 1'b0, 1'b0, 1'b0);

    // Equal target at level 5
    load(1'b1, 4'd5);
    tick(20);
    chk_all("eq.ramp", 4'd5, 1'b0, 1'b1, 1'b1);
    tick(1);
    load(1'b1, 4'd5);
    chk_all("eq.load", 4'd5, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk_all("eq.after", 4'd5, 1'b0, 1'b0, 1'b1);

    // Kill beats a simultaneous load
    load(1'b1, 4'd9);
    tick(8);
    chk_all("kill.pre", 4'd7, 1'b1, 1'b0, 1'b1);
    tick(1);
    chs_mode   = 1'b1;
    chs_power  = 4'd15;
    conf_valid = 1'b1;
    pwr_kill   = 1'b1;
    tick(1);
    chk_all("kill.e0", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    conf_valid = 1'b0;
    tick(2);
    chk_all("kill.hold", 4'd0, 1'b0, 1'b0, 1'b0);
    pwr_kill = 1'b0;
    tick(4);
    chk_all("kill.ignored", 4'd0, 1'b0, 1'b0, 1'b0);
    load(1'b1, 4'd1);
    tick(3);
    chk_all("kill.l3", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_all("kill.l4", 4'd1, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-ramp
    load(1'b1, 4'd8);
    tick(4);
    chk_all("arst.pre", 4'd2, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst.now", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(10);
    chk_all("arst.hold", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
